// File: rtl/foc_dl_pkg.sv
// Shared types and defaults for the FOC deadlock watchdog.
package foc_dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WATCH   = 3'd1,
    ST_SUSPECT = 3'd2,
    ST_REPORT  = 3'd3,
    ST_HOLD    = 3'd4
  } dl_state_e;

  localparam int DEF_NUM_MON = 8;
  localparam int DEF_PERSIST = 1024;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TS_W    = 32;

  // Index width for a flag vector; a single monitor still needs one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/foc_dl_prio_enc.sv
// Lowest-index priority encoder, combinational; all-zero input yields index 0.
module foc_dl_prio_enc #(
  parameter int NUM_MON = 8,
  parameter int SRC_W   = 3
) (
  input  logic [NUM_MON-1:0] vec,
  output logic [SRC_W-1:0]   src
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    src = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (vec[i]) src = i[SRC_W-1:0];
    end
  end

endmodule

// File: rtl/foc_deadlock_watchdog.sv
// Confirms a persistent HLS monitor deadlock and issues one valid/ready report plus a sticky irq.
// Report valid PERSIST_CYCLES+2 cycles after block_in rises; payload holds until dl_ready, then HOLD until clear.
// Optional FOC_DL_TIMESTAMP_EN adds a free-running timestamp captured with the report.
module foc_deadlock_watchdog
  import foc_dl_pkg::*;
#(
  parameter int NUM_MON        = DEF_NUM_MON,
  parameter int PERSIST_CYCLES = DEF_PERSIST,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TS_W           = DEF_TS_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [NUM_MON-1:0]            block_in,
  output logic                          dl_valid,
  input  logic                          dl_ready,
  output logic [NUM_MON-1:0]            dl_mask,
  output logic [src_w(NUM_MON)-1:0]     dl_src,
  output logic [TS_W-1:0]               dl_timestamp,
  output logic                          irq,
  output logic [2:0]                    state_o
);

  localparam int SRC_W = src_w(NUM_MON);

  dl_state_e          state_q, state_d;
  logic [NUM_MON-1:0] blk_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vld_q, vld_d;
  logic               irq_q, irq_d;
  logic [NUM_MON-1:0] mask_q, mask_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   enc_src;
  logic               any_blk;

  assign any_blk = |blk_q;

  foc_dl_prio_enc #(
    .NUM_MON (NUM_MON),
    .SRC_W   (SRC_W)
  ) u_prio_enc (
    .vec (blk_q),
    .src (enc_src)
  );

`ifdef FOC_DL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] tsc_q, tsc_d;

  assign ts_d = ts_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q  <= '0;
      tsc_q <= '0;
    end else begin
      ts_q  <= ts_d;
      tsc_q <= tsc_d;
    end
  end

  always_comb begin
    tsc_d = tsc_q;
    if (enable && !(clear && state_q != ST_IDLE) && state_q == ST_SUSPECT &&
        any_blk && cnt_q == CNT_W'(PERSIST_CYCLES - 1)) begin
      tsc_d = ts_q;
    end
  end

  assign dl_timestamp = tsc_q;
`else
  assign dl_timestamp = '0;
`endif

  // enable low beats clear, which beats normal sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    irq_d   = irq_q;
    mask_d  = mask_q;
    src_d   = src_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      vld_d   = 1'b0;
      irq_d   = 1'b0;
    end else if (clear && state_q != ST_IDLE) begin
      state_d = ST_WATCH;
      cnt_d   = '0;
      vld_d   = 1'b0;
      irq_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WATCH;
        ST_WATCH: begin
          if (any_blk) begin
            state_d = ST_SUSPECT;
            cnt_d   = '0;
          end
        end
        ST_SUSPECT: begin
          if (!any_blk) begin
            state_d = ST_WATCH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(PERSIST_CYCLES - 1)) begin
            state_d = ST_REPORT;
            mask_d  = blk_q;
            src_d   = enc_src;
            vld_d   = 1'b1;
            irq_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_REPORT: begin
          if (vld_q && dl_ready) begin
            state_d = ST_HOLD;
            vld_d   = 1'b0;
          end
        end
        ST_HOLD: state_d = ST_HOLD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      irq_q   <= 1'b0;
      mask_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= block_in;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      irq_q   <= irq_d;
      mask_q  <= mask_d;
      src_q   <= src_d;
    end
  end

  assign dl_valid = vld_q;
  assign irq      = irq_q;
  assign dl_mask  = mask_q;
  assign dl_src   = src_q;
  assign state_o  = state_q;

endmodule
